network_sink: RTL and testbench
===============================

Name: network_sink

Overview:
- Output-side counterpart of the network source: accepts one beat of output spikes per network timestep over a valid/ready handshake.
- Stamps each beat with a per-run timestep index and buffers it in a 2-entry FIFO.
- Presents packed sink words to the host stream with a valid/ready handshake.
- Sits between the network's output ports and the sink serializer / host interface.

Parameters:
- SNK_RUN_WIDTH, 16: width of the per-run timestep index field; the index saturates at 2^SNK_RUN_WIDTH-1.
- SPARSE, 0: when 1, a beat with no spikes and net_last=0 is consumed but no word is emitted.
- Widths from network_config: NET_NUM_OUT (output neuron count). SNK_WIDTH = 1 + SNK_RUN_WIDTH + NET_NUM_OUT.

Ports:
- clk  input  1  single clock; all state on posedge.
- arstn  input  1  asynchronous, active-low reset.
- net_valid  input  1  network output beat valid.
- net_ready  output  1  sink can accept a network beat.
- net_last  input  1  accepted beat is the final timestep of the current run.
- net_out  input  NET_NUM_OUT  output spike bits; index 0 is neuron 0.
- snk_valid  output  1  sink word valid.
- snk_ready  input  1  host accepts sink word.
- snk  output  SNK_WIDTH  packed word, laid out MSB to LSB:
  - last flag (1 bit);
  - timestep index (SNK_RUN_WIDTH bits);
  - spikes, with net_out[0] at bit NET_NUM_OUT-1 and net_out[NET_NUM_OUT-1] at bit 0.

Behaviour:
- Reset (arstn=0, asynchronous):
  - FIFO count=0, tcnt=0, snk_valid=0, snk=0.
  - net_ready=0 while arstn=0.
  - Any buffered words are discarded.
- Handshakes:
  - accept = net_valid && net_ready.
  - pop = snk_valid && snk_ready.
- net_ready = (count < 2). It is a function of registered state only, with no combinational path from snk_ready. At count==2 a beat is not accepted even if a pop occurs in the same cycle.
- Timestep counter tcnt:
  - On accept with net_last=1: tcnt <= 0.
  - On accept with net_last=0: tcnt <= tcnt+1, saturating at all-ones (no wrap).
  - The word formed from an accepted beat uses the pre-update tcnt.
- Emission:
  - push = accept && (!SPARSE || |net_out || net_last).
  - A suppressed beat still advances tcnt.
- FIFO:
  - 2 entries, first-in first-out.
  - Push and pop in the same cycle keep count unchanged.
  - Push at count==0 with no pop: the word appears on snk with snk_valid=1 in the next cycle. Latency is 1 cycle from accept to visible.
  - snk is driven from the head entry.
- snk and snk_valid are registered outputs. While snk_valid=1 and snk_ready=0, snk holds stable.
- When count==0: snk_valid=0, and snk retains its last value (don't-care for checking).
- Full throughput: with snk_ready held at 1, one beat is accepted per cycle indefinitely.
- Simultaneous net_last and saturation: the word carries the saturated index, then tcnt clears to 0.
- No internal state machine beyond count, tcnt and the FIFO pointers; the states are EMPTY (0), ONE (1) and FULL (2):
  - EMPTY -> ONE on push.
  - ONE -> FULL on push without pop.
  - ONE -> EMPTY on pop without push.
  - FULL -> ONE on pop.

Test Plan:
- Streaming: NET_NUM_OUT=4, SNK_RUN_WIDTH=8, snk_ready=1; 4 beats of net_out 4'b0001, 4'b0010, 4'b0000, 4'b1000, the last with net_last=1.
  -> words {0,0,1000b}, {0,1,0100b}, {0,2,0000b}, {1,3,0001b}, each 1 cycle after accept; tcnt=0 afterwards.
- Backpressure: snk_ready=0 and 3 beats offered.
  -> 2 accepted, net_ready=0 from the cycle after the 2nd accept; snk holds word 0 stable.
  -> Raising snk_ready drains words 0 then 1; the 3rd beat is accepted after the first pop.
- Sparse: SPARSE=1; beats 0000b, 0000b, 0100b, then 0000b with net_last=1.
  -> exactly 2 words: {0,2,0010b} and {1,3,0000b}.
- Saturation: SNK_RUN_WIDTH=2; 6 beats, the last with net_last=1.
  -> indices 0, 1, 2, 3, 3, 3 with last set on the 6th; the next beat carries index 0.
- Mid-operation reset: FIFO full, then arstn pulsed low between clock edges.
  -> snk_valid=0 and net_ready=0 immediately; after release net_ready=1 and the next word has index 0.
- Randomized valid/ready on both sides, 1000 beats.
  -> Scoreboard shows no loss or duplication and in-order delivery.
  -> Ready never depends on the same-cycle snk_ready.

Source files
------------

// File: rtl/network_sink.sv
// network_sink: stamps network output beats with a per-run timestep index and buffers them for the host stream
module network_sink #(
    parameter int NET_NUM_OUT   = 4,
    parameter int SNK_RUN_WIDTH = 16,
    parameter bit SPARSE        = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 arstn,
    input  logic                                 net_valid,
    output logic                                 net_ready,
    input  logic                                 net_last,
    input  logic [NET_NUM_OUT-1:0]               net_out,
    output logic                                 snk_valid,
    input  logic                                 snk_ready,
    output logic [SNK_RUN_WIDTH+NET_NUM_OUT:0]   snk
);
    localparam int SNK_WIDTH = 1 + SNK_RUN_WIDTH + NET_NUM_OUT;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} fill_e;

    fill_e                    fill_q;
    logic [SNK_WIDTH-1:0]     snk_q, spare_q, word_d;
    logic [SNK_RUN_WIDTH-1:0] tcnt_q, tcnt_d;
    logic [NET_NUM_OUT-1:0]   spikes_d;
    logic                     snk_valid_q, accept, push, pop;

    // ready is derived from registered fill level only, gated low during reset
    assign net_ready = arstn && (fill_q != FULL);
    assign accept    = net_valid && net_ready;
    assign pop       = snk_valid_q && snk_ready;
    assign push      = accept && (!SPARSE || |net_out || net_last);
    assign snk_valid = snk_valid_q;
    assign snk       = snk_q;

    // word assembly: neuron 0 lands in the most significant spike bit; index saturates within a run
    always_comb begin
        spikes_d = '0;
        for (int i = 0; i < NET_NUM_OUT; i++) spikes_d[i] = net_out[NET_NUM_OUT-1-i];
        word_d = {net_last, tcnt_q, spikes_d};
        tcnt_d = !accept ? tcnt_q : net_last ? '0 : &tcnt_q ? tcnt_q : tcnt_q + SNK_RUN_WIDTH'(1);
    end

    // two-entry FIFO: snk_q is the head, spare_q the second slot; full blocks acceptance
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            fill_q      <= EMPTY;
            snk_q       <= '0;
            spare_q     <= '0;
            snk_valid_q <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            tcnt_q <= tcnt_d;
            case (fill_q)
                EMPTY: if (push) begin
                    snk_q       <= word_d;
                    snk_valid_q <= 1'b1;
                    fill_q      <= ONE;
                end
                ONE: if (push && pop) begin
                    snk_q <= word_d;
                end else if (push) begin
                    spare_q <= word_d;
                    fill_q  <= FULL;
                end else if (pop) begin
                    snk_valid_q <= 1'b0;
                    fill_q      <= EMPTY;
                end
                FULL: if (pop) begin
                    snk_q  <= spare_q;
                    fill_q <= ONE;
                end
                default: fill_q <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_network_sink.sv
// tb_network_sink: table-driven and scoreboard checks of network_sink across dense, sparse and saturating builds
module tb_network_sink;
    logic        clk, arstn, net_valid, net_last, snk_ready;
    logic [3:0]  net_out;
    logic        net_ready_a, net_ready_b, net_ready_c;
    logic        snk_valid_a, snk_valid_b, snk_valid_c;
    logic [12:0] snk_a, snk_b;
    logic [6:0]  snk_c;
    logic        v_valid, v_ready;
    logic [12:0] v_snk;
    int          sel, n_cmp, n_err, pops, occ;
    logic        occ_on, rnd_on, hold;
    logic [12:0] hold_w;
    logic [12:0] exp_q[$];

    typedef struct {
        int          sel;
        logic [3:0]  out;
        logic        last;
        logic        emit;
        logic [12:0] w;
    } vec_t;
    vec_t vt[16];

    network_sink #(.NET_NUM_OUT(4), .SNK_RUN_WIDTH(8), .SPARSE(1'b0)) dut_a (
        .clk(clk), .arstn(arstn), .net_valid(net_valid), .net_ready(net_ready_a), .net_last(net_last),
        .net_out(net_out), .snk_valid(snk_valid_a), .snk_ready(snk_ready), .snk(snk_a));
    network_sink #(.NET_NUM_OUT(4), .SNK_RUN_WIDTH(8), .SPARSE(1'b1)) dut_b (
        .clk(clk), .arstn(arstn), .net_valid(net_valid), .net_ready(net_ready_b), .net_last(net_last),
        .net_out(net_out), .snk_valid(snk_valid_b), .snk_ready(snk_ready), .snk(snk_b));
    network_sink #(.NET_NUM_OUT(4), .SNK_RUN_WIDTH(2), .SPARSE(1'b0)) dut_c (
        .clk(clk), .arstn(arstn), .net_valid(net_valid), .net_ready(net_ready_c), .net_last(net_last),
        .net_out(net_out), .snk_valid(snk_valid_c), .snk_ready(snk_ready), .snk(snk_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        v_valid = sel == 2 ? snk_valid_c : sel == 1 ? snk_valid_b : snk_valid_a;
        v_ready = sel == 2 ? net_ready_c : sel == 1 ? net_ready_b : net_ready_a;
        v_snk   = sel == 2 ? {6'b0, snk_c} : sel == 1 ? snk_b : snk_a;
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] o);
        return {o[0], o[1], o[2], o[3]};
    endfunction

    // scoreboard pop side plus occupancy model for ready and hold-stability checks
    always @(negedge clk) begin
        if (!arstn) begin
            occ  = 0;
            hold = 1'b0;
        end else begin
            if (occ_on) begin
                chk("ready_vs_occupancy", net_ready_a, occ < 2);
                if (hold) begin
                    chk("hold_valid", snk_valid_a, 1);
                    chk("hold_word", snk_a, hold_w);
                end
            end
            if (v_valid && snk_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", v_snk, $time);
                end else chk("sb_word", v_snk, exp_q.pop_front());
            end
            occ  = occ + int'(net_valid && net_ready_a) - int'(snk_valid_a && snk_ready);
            hold = snk_valid_a && !snk_ready;
            hold_w = snk_a;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_on) snk_ready = 1'($urandom_range(0, 1));
    end

    task automatic do_reset();
        arstn = 1'b0;
        net_valid = 1'b0;
        net_last = 1'b0;
        net_out = 4'b0;
        snk_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_a", snk_valid_a, 0);
        chk("rst_valid_c", snk_valid_c, 0);
        chk("rst_ready_a", net_ready_a, 0);
        chk("rst_ready_b", net_ready_b, 0);
        chk("rst_snk_a", snk_a, 0);
        arstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // called at posedge+1; holds the beat until the selected DUT accepts it
    task automatic send(input logic [3:0] o, input logic l, input logic e, input logic [12:0] w);
        int k;
        net_valid = 1'b1;
        net_out = o;
        net_last = l;
        k = 0;
        @(negedge clk);
        while (!v_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!v_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 at %0t", $time);
        end else if (e) exp_q.push_back(w);
        @(posedge clk);
        #1;
        net_valid = 1'b0;
    endtask

    task automatic end_group(input int ne);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("group_pops", pops, ne);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cur, ne, m_t;
        logic [3:0] o;
        logic l;
        n_cmp = 0; n_err = 0; pops = 0; sel = 0;
        occ_on = 1'b0; rnd_on = 1'b0;
        vt[0]  = '{0, 4'b0001, 1'b0, 1'b1, 13'b0_00000000_1000};
        vt[1]  = '{0, 4'b0010, 1'b0, 1'b1, 13'b0_00000001_0100};
        vt[2]  = '{0, 4'b0000, 1'b0, 1'b1, 13'b0_00000010_0000};
        vt[3]  = '{0, 4'b1000, 1'b1, 1'b1, 13'b1_00000011_0001};
        vt[4]  = '{0, 4'b0001, 1'b0, 1'b1, 13'b0_00000000_1000};
        vt[5]  = '{1, 4'b0000, 1'b0, 1'b0, 13'b0};
        vt[6]  = '{1, 4'b0000, 1'b0, 1'b0, 13'b0};
        vt[7]  = '{1, 4'b0100, 1'b0, 1'b1, 13'b0_00000010_0010};
        vt[8]  = '{1, 4'b0000, 1'b1, 1'b1, 13'b1_00000011_0000};
        vt[9]  = '{2, 4'b0001, 1'b0, 1'b1, 13'b000000_0_00_1000};
        vt[10] = '{2, 4'b0001, 1'b0, 1'b1, 13'b000000_0_01_1000};
        vt[11] = '{2, 4'b0001, 1'b0, 1'b1, 13'b000000_0_10_1000};
        vt[12] = '{2, 4'b0001, 1'b0, 1'b1, 13'b000000_0_11_1000};
        vt[13] = '{2, 4'b0001, 1'b0, 1'b1, 13'b000000_0_11_1000};
        vt[14] = '{2, 4'b0001, 1'b1, 1'b1, 13'b000000_1_11_1000};
        vt[15] = '{2, 4'b0001, 1'b0, 1'b1, 13'b000000_0_00_1000};

        cur = -1;
        ne = 0;
        for (int i = 0; i < 16; i++) begin
            if (vt[i].sel != cur) begin
                if (cur >= 0) end_group(ne);
                cur = vt[i].sel;
                sel = cur;
                do_reset();
                snk_ready = 1'b1;
                pops = 0;
                ne = 0;
            end
            send(vt[i].out, vt[i].last, vt[i].emit, vt[i].w);
            ne += int'(vt[i].emit);
            chk("vec_valid", v_valid, vt[i].emit);
            if (vt[i].emit) chk("vec_word", v_snk, vt[i].w);
        end
        end_group(ne);

        sel = 0;
        do_reset();
        occ_on = 1'b1;
        pops = 0;
        send(4'b0001, 1'b0, 1'b1, 13'b0_00000000_1000);
        send(4'b0010, 1'b0, 1'b1, 13'b0_00000001_0100);
        net_valid = 1'b1;
        net_out = 4'b0011;
        net_last = 1'b0;
        @(negedge clk);
        chk("bp_ready_full", net_ready_a, 0);
        chk("bp_valid", snk_valid_a, 1);
        chk("bp_head", snk_a, 13'b0_00000000_1000);
        repeat (3) @(negedge clk);
        chk("bp_head_stable", snk_a, 13'b0_00000000_1000);
        @(posedge clk);
        #1;
        snk_ready = 1'b1;
        send(4'b0011, 1'b0, 1'b1, 13'b0_00000010_1100);
        end_group(3);

        snk_ready = 1'b0;
        send(4'b0001, 1'b0, 1'b1, 13'b0_00000011_1000);
        send(4'b0001, 1'b0, 1'b1, 13'b0_00000100_1000);
        #1;
        arstn = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", snk_valid_a, 0);
        chk("mid_rst_ready", net_ready_a, 0);
        @(negedge clk);
        #1;
        arstn = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready_after", net_ready_a, 1);
        snk_ready = 1'b1;
        pops = 0;
        send(4'b0100, 1'b0, 1'b1, 13'b0_00000000_0010);
        chk("mid_rst_word", snk_a, 13'b0_00000000_0010);
        end_group(1);

        m_t = 1;
        pops = 0;
        rnd_on = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            o = 4'($urandom);
            l = ($urandom_range(0, 15) == 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(o, l, 1'b1, {l, 8'(m_t), rev4(o)});
            m_t = l ? 0 : (m_t == 255 ? 255 : m_t + 1);
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #1;
        snk_ready = 1'b1;
        end_group(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
